// File: rtl/mem32_byte_streamer.sv
// rtl/mem32_byte_streamer.sv - reads the four bytes of mem32 and streams them with an XOR checksum
//
// Purpose: on start, fetch bytes 0..3 (or 3..0) from mem32 one read at a time,
// present each on a valid/ready byte stream, flag the last byte and report
// the XOR of all four bytes.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle request, honoured only in IDLE
//   mem_valid         mem32 holds a complete word
//   mem_data          mem32 Dataout, valid one cycle after the read is sampled
//   mem_rd, mem_addr  read strobe and byte address to mem32
//   out_data, out_valid, out_ready, out_last   byte stream to the sink
//   busy              transfer in progress
//   done              one-cycle pulse after the last byte is accepted
//   chk               XOR of the streamed bytes, held until the next done
//   err               one-cycle pulse on start while mem32 is not valid
module mem32_byte_streamer #(
  parameter int ADDR_ORDER = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mem_valid,
  input  logic [7:0] mem_data,
  output logic       mem_rd,
  output logic [1:0] mem_addr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [7:0] chk,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] acc, acc_n;

  logic       mem_rd_n;
  logic [1:0] mem_addr_n;
  logic [7:0] out_data_n;
  logic       out_valid_n;
  logic       out_last_n;
  logic       busy_n;
  logic       done_n;
  logic [7:0] chk_n;
  logic       err_n;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    acc_n      = acc;
    out_data_n = out_data;
    chk_n      = chk;
    err_n      = 1'b0;
    mem_addr_n = mem_addr;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (mem_valid) begin
            idx_n   = 2'd0;
            acc_n   = 8'h00;
            state_n = S_REQ;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        out_data_n = mem_data;
        acc_n      = acc ^ mem_data;
        state_n    = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          if (idx == 2'd3) begin
            chk_n   = acc;
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe without any combinational path out.
    mem_rd_n    = (state_n == S_REQ);
    out_valid_n = (state_n == S_HOLD);
    out_last_n  = (state_n == S_HOLD) && (idx_n == 2'd3);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    if (state_n == S_REQ) begin
      // 3 - idx is the bitwise inverse for a 2-bit index
      mem_addr_n = (ADDR_ORDER != 0) ? ~idx_n : idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      acc       <= 8'h00;
      mem_rd    <= 1'b0;
      mem_addr  <= 2'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      chk       <= 8'h00;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      acc       <= acc_n;
      mem_rd    <= mem_rd_n;
      mem_addr  <= mem_addr_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
      done      <= done_n;
      chk       <= chk_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_mem32_byte_streamer.sv
// tb/tb_mem32_byte_streamer.sv - self-checking bench for mem32_byte_streamer (both address orders)
module tb_mem32_byte_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, mem_valid, out_ready;
  logic [7:0] mem_data [2];
  logic [1:0] mem_rd, out_valid, out_last, busy, done, err;
  logic [1:0] mem_addr [2];
  logic [7:0] out_data [2];
  logic [7:0] chk [2];
  logic [7:0] mem [4];

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] qb0[$], qb1[$];
  logic [1:0] qa0[$], qa1[$];
  int         rd_cnt [2];
  int         done_cnt [2];
  logic [7:0] exp_chk;
  int         exp_done;

  mem32_byte_streamer #(.ADDR_ORDER(0)) u_fwd (
    .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid), .mem_data(mem_data[0]),
    .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_last(out_last[0]), .busy(busy[0]), .done(done[0]),
    .chk(chk[0]), .err(err[0])
  );

  mem32_byte_streamer #(.ADDR_ORDER(1)) u_rev (
    .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid), .mem_data(mem_data[1]),
    .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_last(out_last[1]), .busy(busy[1]), .done(done[1]),
    .chk(chk[1]), .err(err[1])
  );

  // mem32 read port model: Dataout follows one cycle after rd/addr are sampled
  always @(posedge clk) begin
    if (mem_rd[0]) mem_data[0] <= mem[mem_addr[0]];
    if (mem_rd[1]) mem_data[1] <= mem[mem_addr[1]];
  end

  typedef struct {
    logic [31:0] word;
    int          stall_k;
    int          stall_len;
    logic [7:0]  exp_chk;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input int d, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s dut%0d: got %0h, expected nothing", name, d, act);
  endtask

  function automatic int byte_size(input int d);
    return (d == 0) ? qb0.size() : qb1.size();
  endfunction

  function automatic logic [8:0] byte_front(input int d);
    return (d == 0) ? qb0[0] : qb1[0];
  endfunction

  function automatic logic [8:0] byte_pop(input int d);
    return (d == 0) ? qb0.pop_front() : qb1.pop_front();
  endfunction

  function automatic int addr_size(input int d);
    return (d == 0) ? qa0.size() : qa1.size();
  endfunction

  function automatic logic [1:0] addr_pop(input int d);
    return (d == 0) ? qa0.pop_front() : qa1.pop_front();
  endfunction

  // Stores the word and pushes the expected reads and bytes for both orders.
  task automatic load_word(input logic [31:0] w);
    mem[0] = w[31:24];
    mem[1] = w[23:16];
    mem[2] = w[15:8];
    mem[3] = w[7:0];
    qb0.delete(); qb1.delete(); qa0.delete(); qa1.delete();
    for (int k = 0; k < 4; k++) begin
      qb0.push_back({k == 3, mem[k]});
      qa0.push_back(k[1:0]);
      qb1.push_back({k == 3, mem[3 - k]});
      qa1.push_back(2'(3 - k));
    end
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d]   = 0;
      done_cnt[d] = 0;
    end
  endtask

  task automatic observe(input int L, input bit exp_busy);
    logic [8:0] eb;
    for (int d = 0; d < 2; d++) begin
      if (mem_rd[d] === 1'b1) begin
        rd_cnt[d]++;
        check_eq("rd_during_valid", d, out_valid[d], 0);
        if (addr_size(d) == 0) fail_event("unexpected_rd", d, mem_addr[d]);
        else check_eq("mem_addr", d, mem_addr[d], addr_pop(d));
      end
      if (out_valid[d] === 1'b1) begin
        if (byte_size(d) == 0) fail_event("unexpected_byte", d, out_data[d]);
        else begin
          eb = out_ready ? byte_pop(d) : byte_front(d);
          check_eq("last_data", d, {out_last[d], out_data[d]}, eb);
        end
      end else begin
        check_eq("last_idle", d, out_last[d], 0);
      end
      check_eq("busy", d, busy[d], exp_busy);
      check_eq("err", d, err[d], 0);
      if (done[d] === 1'b1) begin
        done_cnt[d]++;
        check_eq("done_cycle", d, L, exp_done);
        check_eq("chk_at_done", d, chk[d], exp_chk);
      end
    end
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_mem_rd", d, mem_rd[d], 0);
      check_eq("rst_mem_addr", d, mem_addr[d], 0);
      check_eq("rst_out_data", d, out_data[d], 0);
      check_eq("rst_out_valid", d, out_valid[d], 0);
      check_eq("rst_out_last", d, out_last[d], 0);
      check_eq("rst_busy", d, busy[d], 0);
      check_eq("rst_done", d, done[d], 0);
      check_eq("rst_chk", d, chk[d], 0);
      check_eq("rst_err", d, err[d], 0);
    end
  endtask

  // Cycle label L counts from 1 = the cycle after the edge that samples start.
  task automatic run_xfer(input logic [31:0] w, input int sk, input int sl,
                          input logic [7:0] xc, input int xd, input bit noisy);
    int s0;
    load_word(w);
    exp_chk   = xc;
    exp_done  = xd;
    s0        = 3 + 3 * sk;
    mem_valid = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int L = 1; L <= xd + 2; L++) begin
      out_ready = !(L >= s0 && L < s0 + sl);
      if (noisy) begin
        start     = (L == 5) || (L == xd);
        mem_valid = !(L >= 7 && L < xd);
      end
      if (L >= s0 && L < s0 + sl) begin
        check_eq("stall_valid_fwd", 0, out_valid[0], 1);
        check_eq("stall_valid_rev", 1, out_valid[1], 1);
      end
      observe(L, L <= xd);
      tick();
    end
    start     = 1'b0;
    mem_valid = 1'b1;
    out_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check_eq("bytes_left", d, byte_size(d), 0);
      check_eq("reads_left", d, addr_size(d), 0);
      check_eq("rd_count", d, rd_cnt[d], 4);
      check_eq("done_count", d, done_cnt[d], 1);
      check_eq("chk_held", d, chk[d], xc);
    end
  endtask

  initial begin
    vecs[0] = '{32'hA1B2C3D4, 0, 0, 8'h04, 13};
    vecs[1] = '{32'hA1B2C3D4, 1, 5, 8'h04, 18};
    vecs[2] = '{32'h00000000, 0, 0, 8'h00, 13};
    vecs[3] = '{32'hFFFFFFFF, 3, 2, 8'h00, 15};
    vecs[4] = '{32'h12345678, 0, 1, 8'h08, 14};
    vecs[5] = '{32'h80000001, 2, 3, 8'h81, 16};

    rst       = 1'b1;
    start     = 1'b0;
    mem_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].word, vecs[i].stall_k, vecs[i].stall_len,
               vecs[i].exp_chk, vecs[i].exp_done, 1'b0);
    end

    // start without a valid word: err pulse only
    mem_valid = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_eq("err_pulse", d, err[d], 1);
      check_eq("err_busy", d, busy[d], 0);
      check_eq("err_no_rd", d, mem_rd[d], 0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        check_eq("err_cleared", d, err[d], 0);
        check_eq("err_still_idle", d, busy[d], 0);
        check_eq("err_still_no_rd", d, mem_rd[d], 0);
      end
    end

    // start repeated mid-transfer and in the done cycle, mem_valid dropping
    run_xfer(32'h5A3C9612, 0, 0, 8'hE2, 13, 1'b1);

    // reset in the HOLD of byte 2, then a clean transfer
    load_word(32'hA1B2C3D4);
    exp_chk   = 8'h00;
    exp_done  = 0;
    mem_valid = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int L = 1; L <= 9; L++) begin
      out_ready = (L != 9);
      observe(L, 1'b1);
      if (L == 9) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check_reset();
    tick();
    run_xfer(32'hA1B2C3D4, 0, 0, 8'h04, 13, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
